// File: rtl/result_uart_tx.sv
// result_uart_tx: serialises a captured 80-bit score vector as an 11-byte 8N1 UART packet (HEADER first, then din[79:72] down to din[7:0])
//   clk       : system clock, all logic on posedge
//   rst_n     : synchronous active-low reset
//   din       : ten 8-bit class scores, captured when din_valid is accepted
//   din_valid : one-cycle strobe, honoured only while idle
//   tx        : registered UART line, idle high
//   busy      : registered, high while a packet is in flight
module result_uart_tx #(
  parameter int         BAUD_DIV = 434,
  parameter logic [7:0] HEADER   = 8'hAA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [79:0] din,
  input  logic        din_valid,
  output logic        tx,
  output logic        busy
);
  localparam int BW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    byte_q, byte_d;
  logic [79:0]   data_q, data_d;
  logic          tx_q, tx_d, busy_q, busy_d;
  logic          wrap;
  logic [6:0]    sel;
  logic [7:0]    cur;
  assign wrap = baud_q == BW'(BAUD_DIV - 1);
  // byte 1 is data_q[79:72], byte 10 is data_q[7:0]
  assign sel  = {4'd10 - byte_q, 3'b000};
  assign cur  = byte_q == 4'd0 ? HEADER : data_q[sel +: 8];
  assign tx   = tx_q;
  assign busy = busy_q;
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    data_d  = data_q;
    baud_d  = (state_q == IDLE || wrap) ? '0 : baud_q + BW'(1);
    case (state_q)
      IDLE:  if (din_valid) begin
               state_d = START;
               data_d  = din;
             end
      START: if (wrap) state_d = DATA;
      DATA:  if (wrap) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
             end
      STOP:  if (wrap) begin
               state_d = byte_q == 4'd10 ? IDLE : START;
               byte_d  = byte_q == 4'd10 ? 4'd0 : byte_q + 4'd1;
             end
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so they line up with it
    tx_d   = state_d == START ? 1'b0 : state_d == DATA ? cur[bit_d] : 1'b1;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end
endmodule
